// File: rtl/axi_read_responder_pkg.sv
// Shared constants for the AXI read responder: ID width, response codes,
// FSM state encodings and the alignment helper.
package axi_read_responder_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no response pending
        ST_MEM  = 2'd1,   // SRAM read in flight
        ST_RESP = 2'd2    // response presented on R channel
    } state_e;

    // A byte address that is not word aligned is answered with SLVERR.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/axi_read_responder_fifo.sv
// resp_fifo: request queue holding accepted AR entries in acceptance order.
// Ports: push/wdata write side, pop/rdata (head, show-ahead) read side,
//        full/empty/count status from registered state.
module resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Push is refused while full even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder: single-beat AXI read slave in front of a synchronous SRAM.
// Ports: AR channel (arid/araddr/arvalid/arready), R channel
//        (rid/rdata/rresp/rlast/rvalid/rready), SRAM (mem_en/mem_addr/mem_rdata).
// Requests are queued in order; each is issued to SRAM, then answered.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned MEM_AW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ID_W-1:0]      arid,
    input  logic [31:0]          araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [ID_W-1:0]      rid,
    output logic [DATA_W-1:0]    rdata,
    output logic [RESP_W-1:0]    rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 mem_en,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata
);

    localparam int unsigned ENTRY_W = ID_W + MEM_AW + 1;
    localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;

    state_e              state;
    state_e              state_nxt;
    logic                issue_c;

    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic [ID_W-1:0]     head_id;
    logic [MEM_AW-1:0]   head_addr;
    logic                head_err;

    logic [ID_W-1:0]     infl_id;
    logic                infl_err;

    logic                unused_sigs;

    // Entry layout: {id, word address, misaligned flag}.
    assign fifo_wdata = {arid, araddr[MEM_AW+1:2], is_misaligned(araddr)};
    assign head_id    = fifo_head[ENTRY_W-1 -: ID_W];
    assign head_addr  = fifo_head[MEM_AW:1];
    assign head_err   = fifo_head[0];

    assign arready     = !fifo_full;
    assign unused_sigs = ^{araddr[31:MEM_AW+2], fifo_count};

    resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (arvalid && arready),
        .wdata (fifo_wdata),
        .pop   (issue_c),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, issue decision and SRAM request
    always_comb begin
        state_nxt = state;
        issue_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    issue_c   = 1'b1;
                    state_nxt = ST_MEM;
                end
            end
            ST_MEM: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rready) begin
                    if (!fifo_empty) begin
                        issue_c   = 1'b1;
                        state_nxt = ST_MEM;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Misaligned requests never touch the SRAM.
    assign mem_en   = issue_c && !head_err;
    assign mem_addr = head_addr;

    // Remember which request is in flight while SRAM data is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_id  <= '0;
            infl_err <= 1'b0;
        end else if (issue_c) begin
            infl_id  <= head_id;
            infl_err <= head_err;
        end
    end

    // Response register, loaded only when leaving MEM so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rid   <= '0;
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (state == ST_MEM) begin
            rid   <= infl_id;
            rdata <= infl_err ? '0 : mem_rdata;
            rresp <= infl_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign rvalid = (state == ST_RESP);
    assign rlast  = 1'b1;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder with a behavioural SRAM and an R-channel monitor.
module tb_axi_read_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [4096];

    int errs;
    int checks;
    int mem_en_cnt;
    int cyc;
    int max_cnt;

    logic [3:0]  rsp_id   [$];
    logic [31:0] rsp_data [$];
    logic [1:0]  rsp_resp [$];
    int          rsp_cyc  [$];

    axi_read_responder #(.QDEPTH(4), .MEM_AW(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .arid      (arid),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // R-channel and SRAM-enable monitor.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && rvalid && rready) begin
            rsp_id.push_back(rid);
            rsp_data.push_back(rdata);
            rsp_resp.push_back(rresp);
            rsp_cyc.push_back(cyc);
        end
        if (mem_en) mem_en_cnt = mem_en_cnt + 1;
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rsp();
        rsp_id.delete();
        rsp_data.delete();
        rsp_resp.delete();
        rsp_cyc.delete();
    endtask

    // Presents one AR and returns just after the edge where it is accepted; arvalid is left high.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr);
        int t;
        arid    = id;
        araddr  = addr;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin
            step();
            t = t + 1;
        end
        if (t >= 50) check("ar_timeout", 32'(arready), 32'd1);
        step();
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int t;
        t = 0;
        while (rsp_id.size() < n && t < budget) begin
            step();
            t = t + 1;
        end
        check("rsp_count", 32'(rsp_id.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errs       = 0;
        checks     = 0;
        mem_en_cnt = 0;
        cyc        = 0;
        max_cnt    = 0;
        mem_rdata  = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A50000 ^ 32'(i);
        mem[4] = 32'h12345678;

        rst     = 1'b1;
        arid    = '0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rid",     32'(rid),     32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_mem_en",  32'(mem_en),  32'd0);
        rst = 1'b0;
        step();

        // Single read with 2-edge latency
        clear_rsp();
        rready = 1'b1;
        do_ar(4'd0, 32'h0000_0010);
        arvalid = 1'b0;
        check("single_mem_en",   32'(mem_en),   32'd1);
        check("single_mem_addr", 32'(mem_addr), 32'd4);
        check("single_rvalid0",  32'(rvalid),   32'd0);
        step();
        check("single_rvalid1",  32'(rvalid),   32'd0);
        check("single_mem_en1",  32'(mem_en),   32'd0);
        step();
        check("single_rvalid2",  32'(rvalid),   32'd1);
        check("single_rdata",    rdata,         32'h12345678);
        check("single_rid",      32'(rid),      32'd0);
        check("single_rresp",    32'(rresp),    32'd0);
        check("single_rlast",    32'(rlast),    32'd1);
        step();
        check("single_rvalid3",  32'(rvalid),   32'd0);
        check("single_nrsp",     32'(rsp_id.size()), 32'd1);

        // Backpressure: response held stable for 5 cycles
        clear_rsp();
        rready = 1'b0;
        do_ar(4'd3, 32'h0000_0020);
        arvalid = 1'b0;
        step();
        step();
        check("bp_rvalid", 32'(rvalid), 32'd1);
        check("bp_rid",    32'(rid),    32'd3);
        check("bp_rdata",  rdata,       32'hA5A50008);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_rvalid", 32'(rvalid), 32'd1);
            check("bp_hold_rid",    32'(rid),    32'd3);
            check("bp_hold_rdata",  rdata,       32'hA5A50008);
        end
        rready = 1'b1;
        step();
        check("bp_drop", 32'(rvalid), 32'd0);
        check("bp_nrsp", 32'(rsp_id.size()), 32'd1);

        // Fill: 5 requests with rready low; queue ends full
        clear_rsp();
        rready = 1'b0;
        for (int i = 0; i < 5; i++) do_ar(4'(i % 2), 32'h40 + 32'(i * 4));
        arvalid = 1'b0;
        check("fill_arready", 32'(arready), 32'd0);
        rready = 1'b1;
        wait_rsp(5, 40);
        for (int i = 0; i < 5; i++) begin
            if (i < rsp_id.size()) begin
                check("fill_rid",   32'(rsp_id[i]), 32'(i % 2));
                check("fill_rdata", rsp_data[i],    32'hA5A50010 ^ 32'(i));
                if (i > 0) check("fill_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd2);
            end
        end
        step();
        check("fill_arready_end", 32'(arready), 32'd1);

        // Misaligned request answered with SLVERR without an SRAM access
        clear_rsp();
        mem_en_cnt = 0;
        rready = 1'b1;
        do_ar(4'd5, 32'h0000_0006);
        arvalid = 1'b0;
        wait_rsp(1, 20);
        if (rsp_id.size() > 0) begin
            check("mis_rresp", 32'(rsp_resp[0]), 32'd2);
            check("mis_rdata", rsp_data[0],      32'd0);
            check("mis_rid",   32'(rsp_id[0]),   32'd5);
        end
        check("mis_mem_en", 32'(mem_en_cnt), 32'd0);

        // Async reset in RESP with 2 entries queued
        step();
        clear_rsp();
        rready = 1'b0;
        for (int i = 0; i < 3; i++) do_ar(4'(7 + i), 32'h80 + 32'(i * 4));
        arvalid = 1'b0;
        check("rstmid_rvalid_pre", 32'(rvalid), 32'd1);
        check("rstmid_count_pre",  32'(dut.u_fifo.count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_rvalid",  32'(rvalid),  32'd0);
        check("rstmid_arready", 32'(arready), 32'd1);
        check("rstmid_rdata",   rdata,        32'd0);
        step();
        step();
        rst = 1'b0;
        mem_en_cnt = 0;
        rready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("rstmid_nrsp",   32'(rsp_id.size()), 32'd0);
        check("rstmid_mem_en", 32'(mem_en_cnt),    32'd0);
        check("rstmid_rvalid_post", 32'(rvalid),   32'd0);

        // Wrap: 12 back-to-back requests with rready high
        clear_rsp();
        max_cnt = 0;
        rready = 1'b1;
        for (int i = 0; i < 12; i++) do_ar(4'(i), 32'h100 + 32'(i * 4));
        arvalid = 1'b0;
        wait_rsp(12, 200);
        for (int i = 0; i < 12; i++) begin
            if (i < rsp_id.size()) begin
                check("wrap_rid",   32'(rsp_id[i]), 32'(i));
                check("wrap_rdata", rsp_data[i],    32'hA5A50040 ^ 32'(i));
            end
        end
        check("wrap_max_count", 32'(max_cnt <= 4), 32'd1);
        step();
        check("wrap_idle_rvalid", 32'(rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter QDEPTH, default 4: outstanding AR queue depth, power of two, at least 2.
REQ-002 Parameter MEM_AW, default 12: word-address width of the backing SRAM.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 arid  in  4  read request ID.
REQ-006 araddr  in  32  byte address.
REQ-007 arvalid  in  1  request valid.
REQ-008 arready  out  1  queue can accept a request.
REQ-009 rid  out  4  response ID, equal to the accepted arid.
REQ-010 rdata  out  32  response data word.
REQ-011 rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-012 rlast  out  1  end of burst; tied to 1 because every response is a single beat.
REQ-013 rvalid  out  1  response valid.
REQ-014 rready  in  1  master accepts the response.
REQ-015 mem_en  out  1  SRAM read enable.
REQ-016 mem_addr  out  MEM_AW  SRAM word address, taken from araddr[MEM_AW+1:2].
REQ-017 mem_rdata  in  32  SRAM read data, valid one cycle after mem_en.

Function
REQ-018 An AR handshake occurs when arvalid && arready at a rising edge; {arid, araddr[MEM_AW+1:2], err} is pushed into a FIFO with err = (araddr[1:0] != 0).
REQ-019 arready = !full, and depends only on registered count; a push is never accepted while the FIFO is full, even if a pop happens in the same cycle.
REQ-020 Responses are returned strictly in acceptance order, whatever their IDs.
REQ-021 The FSM has three states. IDLE: no response pending. MEM: SRAM access in flight. RESP: rvalid = 1.
REQ-022 Issue condition = FIFO non-empty && (state==IDLE || (state==RESP && rready)); when it holds: pop, go to MEM, and drive mem_en = !head.err combinationally.
REQ-023 In RESP with rready and an empty FIFO, the next state is IDLE; in RESP with !rready, the state is held.
REQ-024 MEM always goes to RESP after one cycle, capturing mem_rdata into rdata (or 0 when err), rid, and rresp (2'b10 when err, else 2'b00).
REQ-025 Latency: with an empty FIFO and the FSM in IDLE, an AR handshake at edge N gives rvalid = 1 after edge N+2.
REQ-026 Throughput: at most one response every 2 cycles with rready held high.
REQ-027 rid, rdata and rresp are stable while rvalid && !rready.
REQ-028 A simultaneous push and pop updates the FIFO correctly, leaves count unchanged, and keeps pointers wrapping modulo QDEPTH.
REQ-029 mem_en is never asserted outside an issue event.

Reset
REQ-030 When rst is asserted, regardless of clock: state = IDLE, FIFO pointers and count = 0, arready = 1, rvalid = 0, rid = 0, rdata = 0, rresp = 0, mem_en = 0.
REQ-031 Reset mid-transaction discards every queued and in-flight request; no response is produced for them after release.

Structure
REQ-032 A shared package holds the response codes (RESP_OKAY, RESP_SLVERR), the FSM state encodings, and the ID width constant (4).
REQ-033 The request queue is a sub-module named resp_fifo (parameterised width and depth, push/pop/full/empty/count); the FSM and response register stay in the top module.

Verification
REQ-034 Single read: araddr=0x00000010, arid=0, rready=1, mem[4]=0x12345678 -> rvalid after 2 edges, rdata=0x12345678, rid=0, rresp=0, rlast=1.
REQ-035 Backpressure: rready=0 for 5 cycles, then 1 -> rvalid held, rid/rdata unchanged until the handshake, then rvalid drops (FIFO empty).
REQ-036 Fill: 5 AR requests (IDs 0,1,0,1,0) with rready=0 -> arready=0 once 4 entries are queued in the FIFO; releasing rready returns IDs in order 0,1,0,1,0, one every 2 cycles.
REQ-037 Misaligned: araddr=0x00000006 -> rresp=2'b10, rdata=0, mem_en never asserted for it.
REQ-038 Async reset asserted while in RESP with 2 entries queued -> rvalid=0 immediately, arready=1, and no responses appear after release.
REQ-039 Wrap/simultaneous: 12 back-to-back requests with rready=1 and arvalid held -> all 12 returned in order, count never exceeds 4, no request lost.
